// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C register target model.
package i2c_tgt_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_e;

    localparam logic [6:0] DefaultTargetAddr = 7'h50;
    localparam logic [7:0] RegResetXor       = 8'hA5;

endpackage

// File: rtl/i2c_tgt_sync.sv
// Two-flop synchronisers for SCL/SDA plus SCL edge and START/STOP pulses.
module i2c_tgt_sync
    import i2c_tgt_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_q;
    logic       sda_q;

    // Reset to the idle bus level so no spurious edge appears after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl_i};
            sda_ff <= {sda_ff[0], sda_i};
            scl_q  <= scl_ff[1];
            sda_q  <= sda_ff[1];
        end
    end

    assign sda_o      = sda_ff[1];
    assign scl_rise_o = scl_ff[1] & ~scl_q;
    assign scl_fall_o = ~scl_ff[1] & scl_q;
    // SCL must be high in both samples so an SDA change at an SCL edge is not an event.
    assign start_o    = scl_ff[1] & scl_q & sda_q & ~sda_ff[1];
    assign stop_o     = scl_ff[1] & scl_q & ~sda_q & sda_ff[1];

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a small register file; optional clock stretching under I2C_TGT_STRETCH_EN.
// wr_valid_o is a one-cycle strobe with no ready: wr_idx_o/wr_data_o are valid in that cycle.
module i2c_reg_target
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] TargetAddr    = DefaultTargetAddr,
    parameter int         NumRegs       = 16,
    parameter int         StretchCycles = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       sda_oe_o,
    output logic                       busy_o,
    output logic                       wr_valid_o,
    output logic [$clog2(NumRegs)-1:0] wr_idx_o,
    output logic [7:0]                 wr_data_o
`ifdef I2C_TGT_STRETCH_EN
    ,
    output logic                       scl_oe_o
`endif
);

    localparam int IdxW = $clog2(NumRegs);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_tgt_sync u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_en;
    logic              ack_end;
    logic [7:0]        byte_in;
    logic [7:0]        rd_byte;
    logic [7:0]        regs_q [NumRegs];

    assign byte_in = {shift_q, sda_s};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        rw_d     = rw_q;
        sda_oe_d = sda_oe_q;
        wr_en    = 1'b0;
        ack_end  = 1'b0;
        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == ADDR) begin
                                rw_d    = byte_in[0];
                                state_d = (byte_in[7:1] == TargetAddr) ? ADDR_ACK : IGNORE;
                            end else if (state_q == PTR) begin
                                ptr_d   = byte_in[IdxW-1:0];
                                state_d = PTR_ACK;
                            end else begin
                                wr_en   = 1'b1;
                                ptr_d   = ptr_q + 1'b1;
                                state_d = WR_ACK;
                            end
                        end
                    end
                end
                // cnt_q==0: waiting for the fall that opens the ACK; 1: ACK is being driven.
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            sda_oe_d = 1'b1;
                            cnt_d    = 4'd1;
                        end else begin
                            ack_end  = 1'b1;
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_d  = RD_DATA;
                                sda_oe_d = ~rd_byte[7];
                                cnt_d    = 4'd1;
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WR_DATA;
                            end
                        end
                    end
                end
                // cnt_q counts bits already placed on the bus for the current byte.
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = RD_ACK;
                        end else begin
                            sda_oe_d = ~rd_byte[3'(4'd7 - cnt_q)];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d   = ptr_q + 1'b1;
                            cnt_d   = 4'd0;
                            state_d = RD_DATA;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 7'd0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_idx_o   <= '0;
            wr_data_o  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_o <= wr_en;
            if (wr_en) begin
                wr_idx_o  <= ptr_q;
                wr_data_o <= byte_in;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= 8'(i) ^ RegResetXor;
            end
        end else if (wr_en) begin
            regs_q[ptr_q] <= byte_in;
        end
    end

    // Events release the bus in the detection cycle rather than one cycle later.
    assign sda_oe_o = sda_oe_q & ~start_det & ~stop_det;
    assign busy_o   = (state_q != IDLE);

`ifdef I2C_TGT_STRETCH_EN
    localparam int SclW = $clog2(StretchCycles + 1);

    logic [SclW-1:0] stretch_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stretch_q <= '0;
        end else if (start_det || stop_det) begin
            stretch_q <= '0;
        end else if (ack_end) begin
            stretch_q <= SclW'(StretchCycles);
        end else if (stretch_q != '0) begin
            stretch_q <= stretch_q - 1'b1;
        end
    end

    assign scl_oe_o = (stretch_q != '0) & ~start_det & ~stop_det;
`else
    logic unused_stretch;
    assign unused_stretch = ack_end | (StretchCycles == 0);
`endif

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged controller on a wired-AND bus.
module tb_i2c_reg_target;

    localparam int IDX_W = 4;
    localparam int W     = IDX_W + 8;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             scl_drv = 1'b1;
    logic             sda_drv = 1'b1;
    logic             scl_bus, sda_bus;
    logic             sda_oe, busy, wr_valid, scl_oe;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_data;

    i2c_reg_target #(
        .TargetAddr    (7'h50),
        .NumRegs       (16),
        .StretchCycles (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl_bus),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe),
        .busy_o     (busy),
        .wr_valid_o (wr_valid),
        .wr_idx_o   (wr_idx),
`ifdef I2C_TGT_STRETCH_EN
        .scl_oe_o   (scl_oe),
`endif
        .wr_data_o  (wr_data)
    );

`ifndef I2C_TGT_STRETCH_EN
    assign scl_oe = 1'b0;
`endif

    assign scl_bus = scl_drv & ~scl_oe;
    assign sda_bus = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard of committed writes, {idx, data}.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           n_cmp = 0;
    int           oe_cycles = 0;
    int           run = 0;
    int           runs[$];

    always @(negedge clk) begin
        if (wr_valid) got_q.push_back({wr_idx, wr_data});
        if (sda_oe) oe_cycles++;
        if (scl_oe) run++;
        else if (run != 0) begin
            runs.push_back(run);
            run = 0;
        end
    end

    task automatic check_writes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = n_cmp; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
        n_cmp = exp_q.size();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up();
        int t;
        t = 0;
        scl_drv = 1'b1;
        @(negedge clk);
        while (scl_bus !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (scl_bus !== 1'b1) check("scl_release", scl_bus, 1);
    endtask

    task automatic start_cond();
        sda_drv = 1'b1; wait_clks(4);
        scl_up();       wait_clks(10);
        sda_drv = 1'b0; wait_clks(10);
        scl_drv = 1'b0; wait_clks(4);
    endtask

    task automatic stop_cond();
        sda_drv = 1'b0; wait_clks(4);
        scl_up();       wait_clks(10);
        sda_drv = 1'b1; wait_clks(10);
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b;    wait_clks(8);
        scl_up();       wait_clks(10);
        scl_drv = 1'b0; wait_clks(4);
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; wait_clks(8);
        scl_up();       wait_clks(5);
        b = sda_bus;    wait_clks(5);
        scl_drv = 1'b0; wait_clks(4);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack);
    endtask

    // Set the pointer then read one byte with NACK.
    task automatic read_reg(input string tag, input logic [7:0] idx, input logic [7:0] exp);
        logic ack;
        logic [7:0] d;
        start_cond();
        send_byte(8'hA0, ack); check({tag, "_aack"}, ack, 0);
        send_byte(idx, ack);   check({tag, "_pack"}, ack, 0);
        start_cond();
        send_byte(8'hA1, ack); check({tag, "_rack"}, ack, 0);
        read_byte(d, 1'b1);    check({tag, "_data"}, d, exp);
        stop_cond();
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         t;
        int         oe0;
        int         r0;

        wait_clks(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_idx", wr_idx, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_scl_oe", scl_oe, 0);
        rst_n = 1'b1;
        wait_clks(5);

        // Write with auto-increment.
        start_cond();
        send_byte(8'hA0, ack); check("wr_addr_ack", ack, 0);
        check("wr_busy", busy, 1);
        send_byte(8'h03, ack); check("wr_ptr_ack", ack, 0);
        send_byte(8'h11, ack); check("wr_d0_ack", ack, 0);
        exp_q.push_back(12'h311);
        send_byte(8'h22, ack); check("wr_d1_ack", ack, 0);
        exp_q.push_back(12'h422);
        stop_cond();
        check("wr_idle", busy, 0);
        check_writes("wr");

        // Combined write/read with pointer wrap.
        start_cond();
        send_byte(8'hA0, ack); check("rd_addr_ack", ack, 0);
        send_byte(8'h0F, ack); check("rd_ptr_ack", ack, 0);
        start_cond();
        send_byte(8'hA1, ack); check("rd_raddr_ack", ack, 0);
        read_byte(d, 1'b0);    check("rd_byte0", d, 8'hAA);
        read_byte(d, 1'b1);    check("rd_byte1_wrap", d, 8'hA5);
        wait_clks(4);
        check("rd_release", sda_oe, 0);
        stop_cond();
        check_writes("rd_wr");
        read_reg("rb3", 8'h03, 8'h11);
        read_reg("rb4", 8'h04, 8'h22);

        // Wrong address: the target must stay off the bus.
        oe0 = oe_cycles;
        start_cond();
        send_byte(8'hB0, ack); check("wa_addr_nack", ack, 1);
        check("wa_busy", busy, 1);
        send_byte(8'h03, ack); check("wa_b1_nack", ack, 1);
        send_byte(8'h99, ack); check("wa_b2_nack", ack, 1);
        check("wa_busy_hold", busy, 1);
        stop_cond();
        check("wa_oe_cycles", oe_cycles - oe0, 0);
        check("wa_idle", busy, 0);
        check_writes("wa_wr");

        // STOP after four data bits discards the byte.
        start_cond();
        send_byte(8'hA0, ack); check("sm_addr_ack", ack, 0);
        send_byte(8'h05, ack); check("sm_ptr_ack", ack, 0);
        write_bit(1'b0); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        stop_cond();
        check("sm_idle", busy, 0);
        check_writes("sm_wr");
        read_reg("sm_rb5", 8'h05, 8'hA0);

        // Reset while the target drives a 0 read bit.
        start_cond();
        send_byte(8'hA0, ack); check("rr_addr_ack", ack, 0);
        send_byte(8'h00, ack); check("rr_ptr_ack", ack, 0);
        send_byte(8'h77, ack); check("rr_d_ack", ack, 0);
        exp_q.push_back(12'h077);
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h00, ack);
        start_cond();
        send_byte(8'hA1, ack); check("rr_raddr_ack", ack, 0);
        check_writes("rr_wr");
        t = 0;
        while (sda_oe !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rr_driving", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rr_sda_oe", sda_oe, 0);
        check("rr_busy", busy, 0);
        wait_clks(2);
        scl_drv = 1'b1; wait_clks(4);
        sda_drv = 1'b1; wait_clks(4);
        rst_n = 1'b1;
        wait_clks(5);
        read_reg("rr_rb0", 8'h00, 8'hA5);

`ifdef I2C_TGT_STRETCH_EN
        // Every ACK the target issues is followed by an 8-cycle SCL hold.
        wait_clks(5);
        r0 = runs.size();
        start_cond();
        send_byte(8'hA0, ack); check("st_addr_ack", ack, 0);
        send_byte(8'h02, ack); check("st_ptr_ack", ack, 0);
        send_byte(8'h5A, ack); check("st_d_ack", ack, 0);
        exp_q.push_back(12'h25A);
        stop_cond();
        wait_clks(20);
        check("st_runs", runs.size() - r0, 3);
        for (int i = r0; i < runs.size(); i++) check("st_len", runs[i], 8);
        check_writes("st_wr");
        read_reg("st_rb2", 8'h02, 8'h5A);
`else
        r0 = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
